imm_encoder: RTL and testbench

- Inverse of the core's immediate extender: takes a 32-bit signed immediate, an ImmSrc type code and a base instruction word, and scatters the immediate into the type's bit positions.
- Used by the boot/patch path that writes assembled instructions into instruction memory ahead of the ICACHE.
- Two-stage pipeline with valid/ready on both sides: range check in stage 1, packing and output hold in stage 2.

---
 rtl/imm_encoder.sv | 188 ++++++++++++++++++
 tb/tb_imm_encoder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - scatters a signed immediate into an instruction word by ImmSrc type
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_valid/in_ready     request handshake (in_imm, in_src, in_base)
//   in_imm                signed immediate (byte offset for B_T/J_T)
//   in_src                ImmSrc code: 111 L_T, 000 I_T, 001 S_T, 010 B_T,
//                         011 J_T, 100 U_T, 101 sra, 110 slli_srli
//   in_base               instruction with non-immediate fields already set
//   out_valid/out_ready   result handshake (out_instr, out_err)
//   out_instr             packed instruction
//   out_err               00 ok, 01 out of range, 10 misaligned
//   ok_count, err_count   saturating counts of delivered ok / error results
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_imm,
    input  logic [2:0]       in_src,
    input  logic [31:0]      in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [1:0]       out_err,
    output logic [CNT_W-1:0] ok_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [2:0] SRC_I   = 3'b000;
    localparam logic [2:0] SRC_S   = 3'b001;
    localparam logic [2:0] SRC_B   = 3'b010;
    localparam logic [2:0] SRC_J   = 3'b011;
    localparam logic [2:0] SRC_U   = 3'b100;
    localparam logic [2:0] SRC_SRA = 3'b101;
    localparam logic [2:0] SRC_SH  = 3'b110;
    localparam logic [2:0] SRC_L   = 3'b111;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage 1 holding registers
    logic        s1_valid;
    logic [31:0] s1_imm;
    logic [2:0]  s1_src;
    logic [31:0] s1_base;
    logic [1:0]  s1_err;

    // Handshake
    logic s2_free;
    logic s1_move;
    logic accept;

    assign s2_free  = !out_valid || out_ready;
    assign s1_move  = s1_valid && s2_free;
    assign in_ready = !s1_valid || s1_move;
    assign accept   = in_valid && in_ready;

    // Range / alignment check on the incoming request
    logic signed [31:0] simm;
    logic               rng_ok;
    logic               misal;
    logic [1:0]         in_err;

    assign simm = in_imm;

    always_comb begin
        rng_ok = 1'b1;
        case (in_src)
            SRC_I, SRC_S:    rng_ok = (simm >= -32'sd2048)    && (simm <= 32'sd2047);
            SRC_L:           rng_ok = (simm >= -32'sd512)     && (simm <= 32'sd511);
            SRC_B:           rng_ok = (simm >= -32'sd2048)    && (simm <= 32'sd2046);
            SRC_J:           rng_ok = (simm >= -32'sd1048576) && (simm <= 32'sd1048574);
            SRC_SRA, SRC_SH: rng_ok = (simm >= 32'sd0)        && (simm <= 32'sd31);
            default:         rng_ok = 1'b1;
        endcase
    end

    assign misal  = (((in_src == SRC_B) || (in_src == SRC_J)) && in_imm[0])
                  || ((in_src == SRC_U) && (in_imm[11:0] != 12'd0));
    // Misalignment wins over range
    assign in_err = misal ? ERR_ALIGN : (!rng_ok ? ERR_RANGE : ERR_OK);

    // Packing of the stage-1 request
    logic [31:0] mask;
    logic [31:0] fields;
    logic [31:0] packed_word;

    always_comb begin
        mask   = 32'h0000_0000;
        fields = 32'h0000_0000;
        case (s1_src)
            SRC_I: begin
                mask   = 32'hFFF0_0000;
                fields = {s1_imm[11:0], 20'b0};
            end
            SRC_L: begin
                mask   = 32'hFFF0_0000;
                fields = {2'b00, s1_imm[9:0], 20'b0};
            end
            SRC_S: begin
                mask   = 32'hFE00_0F80;
                fields = {s1_imm[11:5], 13'b0, s1_imm[4:0], 7'b0};
            end
            SRC_B: begin
                // Bit 7 carries imm[11]; within the accepted range imm[11]
                // equals imm[12], so this matches the standard B layout.
                mask   = 32'hFE00_0F80;
                fields = {s1_imm[11], s1_imm[10:5], 13'b0, s1_imm[4:1], s1_imm[11], 7'b0};
            end
            SRC_J: begin
                mask   = 32'hFFFF_F000;
                fields = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], 12'b0};
            end
            SRC_U: begin
                mask   = 32'hFFFF_F000;
                fields = {s1_imm[31:12], 12'b0};
            end
            SRC_SRA: begin
                mask   = 32'hFFF0_0000;
                fields = {7'b0100000, s1_imm[4:0], 20'b0};
            end
            SRC_SH: begin
                mask   = 32'hFFF0_0000;
                fields = {7'b0000000, s1_imm[4:0], 20'b0};
            end
            default: begin
                mask   = 32'h0000_0000;
                fields = 32'h0000_0000;
            end
        endcase
    end

    // Errored requests clear the immediate positions and keep the base fields
    assign packed_word = (s1_err == ERR_OK) ? ((s1_base & ~mask) | fields)
                                            : (s1_base & ~mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_imm    <= 32'h0;
            s1_src    <= 3'b000;
            s1_base   <= 32'h0;
            s1_err    <= ERR_OK;
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_err   <= ERR_OK;
            ok_count  <= '0;
            err_count <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_imm   <= in_imm;
                s1_src   <= in_src;
                s1_base  <= in_base;
                s1_err   <= in_err;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end

            if (s1_move) begin
                out_valid <= 1'b1;
                out_instr <= packed_word;
                out_err   <= s1_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (out_valid && out_ready) begin
                if (out_err == ERR_OK) begin
                    if (ok_count != {CNT_W{1'b1}}) begin
                        ok_count <= ok_count + CNT_ONE;
                    end
                end else begin
                    if (err_count != {CNT_W{1'b1}}) begin
                        err_count <= err_count + CNT_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - self-checking bench for imm_encoder
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_imm;
    logic [2:0]  in_src;
    logic [31:0] in_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  out_err;
    logic [15:0] ok_count;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    imm_encoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_src    (in_src),
        .in_base   (in_base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .ok_count  (ok_count),
        .err_count (err_count)
    );

    localparam logic [2:0] T_I = 3'b000, T_S = 3'b001, T_B = 3'b010, T_J = 3'b011;
    localparam logic [2:0] T_U = 3'b100, T_SRA = 3'b101, T_SH = 3'b110, T_L = 3'b111;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  err;
        logic [31:0] imm;
        logic [2:0]  src;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] ok_m = 16'd0;
    logic [15:0] err_m = 16'd0;
    bit          last_acc;
    int          dlv_cnt = 0;

    // Reference encoder: range limits as plain integers, fields placed by type
    function automatic exp_t model(input logic [31:0] imm, input logic [2:0] src,
                                   input logic [31:0] base);
        exp_t        r;
        int          v;
        int          lo;
        int          hi;
        bit          ranged;
        bit          misal;
        logic [31:0] m;
        logic [31:0] f;
        v = $signed(imm);
        lo = 0; hi = 0; ranged = 1'b1; misal = 1'b0;
        m = 32'h0; f = 32'h0;
        case (src)
            T_I: begin lo = -2048; hi = 2047; m = 32'hFFF00000; f[31:20] = imm[11:0]; end
            T_L: begin lo = -512; hi = 511; m = 32'hFFF00000; f[29:20] = imm[9:0]; end
            T_S: begin
                lo = -2048; hi = 2047; m = 32'hFE000F80;
                f[31:25] = imm[11:5]; f[11:7] = imm[4:0];
            end
            T_B: begin
                lo = -2048; hi = 2046; misal = (v % 2 != 0); m = 32'hFE000F80;
                f[31] = imm[11]; f[30:25] = imm[10:5]; f[11:8] = imm[4:1]; f[7] = imm[11];
            end
            T_J: begin
                lo = -1048576; hi = 1048574; misal = (v % 2 != 0); m = 32'hFFFFF000;
                f[31] = imm[20]; f[30:21] = imm[10:1]; f[20] = imm[11]; f[19:12] = imm[19:12];
            end
            T_U: begin
                ranged = 1'b0; misal = ((imm % 32'd4096) != 32'd0); m = 32'hFFFFF000;
                f[31:12] = imm[31:12];
            end
            T_SRA: begin lo = 0; hi = 31; m = 32'hFFF00000; f[31:25] = 7'b0100000; f[24:20] = imm[4:0]; end
            default: begin lo = 0; hi = 31; m = 32'hFFF00000; f[24:20] = imm[4:0]; end
        endcase
        if (misal)                             r.err = 2'b10;
        else if (ranged && (v < lo || v > hi)) r.err = 2'b01;
        else                                   r.err = 2'b00;
        r.instr = (r.err == 2'b00) ? ((base & ~m) | f) : (base & ~m);
        r.imm = imm;
        r.src = src;
        return r;
    endfunction

    // The core's immediate extender, used for the round-trip property
    function automatic logic [31:0] extend(input logic [31:0] i, input logic [2:0] src);
        case (src)
            T_I:     return {{20{i[31]}}, i[31:20]};
            T_L:     return {{22{i[29]}}, i[29:20]};
            T_S:     return {{20{i[31]}}, i[31:25], i[11:7]};
            T_B:     return {{20{i[31]}}, i[31], i[30:25], i[11:8], 1'b0};
            T_J:     return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            T_U:     return {i[31:12], 12'b0};
            default: return {29'b0, i[22:20]};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Evaluate handshakes for the coming edge, advance one cycle, land on negedge
    task automatic tick();
        exp_t        e;
        logic [31:0] rt;
        #1;
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            dlv_cnt++;
            total++;
            assert (sb.size() != 0)
            else begin
                bad++;
                $error("FAIL stray_output observed=0x%08h expected=no_output", out_instr);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_instr", out_instr, e.instr);
                chk("out_err", {30'b0, out_err}, {30'b0, e.err});
                if (e.err == 2'b00) begin
                    if (ok_m != 16'hFFFF) ok_m = ok_m + 16'd1;
                    rt = extend(out_instr, e.src);
                    if (e.src == T_SRA || e.src == T_SH)
                        chk("roundtrip_shamt", rt, {29'b0, e.imm[2:0]});
                    else
                        chk("roundtrip", rt, e.imm);
                end else begin
                    if (err_m != 16'hFFFF) err_m = err_m + 16'd1;
                end
            end
        end
        if (last_acc) sb.push_back(model(in_imm, in_src, in_base));
        @(posedge clk);
        @(negedge clk);
        chk("ok_count", {16'b0, ok_count}, {16'b0, ok_m});
        chk("err_count", {16'b0, err_count}, {16'b0, err_m});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_ok_count", {16'b0, ok_count}, 32'd0);
        chk("rst_err_count", {16'b0, err_count}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", {30'b0, out_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        ok_m = 16'd0;
        err_m = 16'd0;
    endtask

    task automatic drive(input logic [31:0] imm, input logic [2:0] src, input logic [31:0] base);
        in_valid = 1'b1;
        in_imm = imm;
        in_src = src;
        in_base = base;
    endtask

    // Single request with out_ready high: output appears two edges after it is presented
    task automatic single(input string tag, input logic [31:0] imm, input logic [2:0] src,
                          input logic [31:0] base, input logic [31:0] exp_instr,
                          input logic [1:0] exp_err);
        out_ready = 1'b1;
        drive(imm, src, base);
        tick();
        chk({tag, "_accepted"}, {31'b0, last_acc}, 32'd1);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, {31'b0, out_valid}, 32'd0);
        tick();
        chk({tag, "_lat2"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_instr"}, out_instr, exp_instr);
        chk({tag, "_err"}, {30'b0, out_err}, {30'b0, exp_err});
        tick();
    endtask

    int          bnd[17] = '{-1048577, -1048576, -2049, -2048, -513, -512, 0, 31, 32,
                             511, 512, 2046, 2047, 2048, 1048574, 1048575, 1048576};
    logic [31:0] bimm[10] = '{32'hFFFFF800, 32'hFFFFF7FF, 32'd511, 32'd512, 32'd2046,
                              32'd2048, 32'h12345000, 32'h12345001, 32'hFFF00000, 32'd31};
    logic [2:0]  bsrc[10] = '{T_I, T_S, T_L, T_L, T_B, T_B, T_U, T_U, T_J, T_SRA};
    logic [1:0]  berr[10] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};

    initial begin
        exp_t        e;
        int          idx;
        int          sel;
        logic [31:0] r_imm;

        rst = 1'b1;
        in_valid = 1'b0;
        in_imm = 32'h0;
        in_src = 3'b000;
        in_base = 32'h0;
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        single("i_neg1", 32'hFFFFFFFF, T_I, 32'h00000013, 32'hFFF00013, 2'b00);
        chk("i_ok_count", {16'b0, ok_count}, 32'd1);
        single("b_neg4", 32'hFFFFFFFC, T_B, 32'h00000063, 32'hFE000EE3, 2'b00);
        single("b_odd", 32'd3, T_B, 32'h00000063, 32'h00000063, 2'b10);

        do_reset();
        single("j_2048", 32'd2048, T_J, 32'h000000EF, 32'h001000EF, 2'b00);
        single("j_over", 32'h00100000, T_J, 32'h000000EF, 32'h000000EF, 2'b01);
        chk("j_err_count", {16'b0, err_count}, 32'd1);

        single("sra_5", 32'd5, T_SRA, 32'h00005013, 32'h40505013, 2'b00);
        single("sh_32", 32'd32, T_SH, 32'h00001013, 32'h00001013, 2'b01);

        for (int k = 0; k < 10; k++) begin
            e = model(bimm[k], bsrc[k], 32'h00000F93);
            single($sformatf("bnd%0d", k), bimm[k], bsrc[k], 32'h00000F93, e.instr, berr[k]);
        end

        // Three back-to-back requests against a stalled consumer
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            drive(idx + 1, T_I, 32'h00000013);
            tick();
            if (last_acc) idx++;
        end
        chk("bp_accepts", idx, 32'd2);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_hold_instr", out_instr, 32'h00100013);
        out_ready = 1'b1;
        dlv_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            if (idx < 3) drive(idx + 1, T_I, 32'h00000013);
            else in_valid = 1'b0;
            tick();
            if (last_acc) idx++;
        end
        in_valid = 1'b0;
        chk("drain_accepts", idx, 32'd3);
        chk("drain_count", dlv_cnt, 32'd3);
        chk("drain_empty", sb.size(), 32'd0);

        // Reset with two requests in flight
        out_ready = 1'b0;
        drive(32'd7, T_I, 32'h00000013);
        tick();
        drive(32'd8, T_I, 32'h00000013);
        tick();
        do_reset();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        chk("post_rst_idle", {31'b0, out_valid}, 32'd0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       r_imm = $urandom_range(0, 80) - 40;
                1:       r_imm = bnd[$urandom_range(0, 16)] + ($urandom_range(0, 2) - 1);
                2:       r_imm = $urandom;
                default: r_imm = $urandom & 32'hFFFFF000;
            endcase
            in_valid = ($urandom_range(0, 3) != 0);
            in_imm = r_imm;
            in_src = 3'($urandom_range(0, 7));
            in_base = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
        chk("final_drain", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
